// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and defaults for the parameter streamer.
package nn_pkg;

   localparam int NN_DW = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_READY  = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   // Address width of a store; a one-word store still needs a 1-bit address.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/param_streamer_if.sv
// rtl/param_streamer_if.sv - host load bus into the parameter streamer.
interface param_streamer_if #(
   parameter int DW = 16
);
   logic          ld_valid;
   logic          ld_ready;
   logic          ld_sel;
   logic [DW-1:0] ld_data;
   logic          ld_last;

   modport master (output ld_valid, ld_sel, ld_data, ld_last, input ld_ready);
   modport slave  (input ld_valid, ld_sel, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/param_store.sv
// rtl/param_store.sv - single write port store with asynchronous read.
module param_store #(
   parameter int DW    = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/param_streamer.sv
// rtl/param_streamer.sv - loads weight/bias stores, then streams them to an engine.
// Optional running checksum of consumed words: PARAM_STREAMER_CKSUM_EN.
module param_streamer
   import nn_pkg::*;
#(
   parameter int DW         = NN_DW,
   parameter int WT_DEPTH   = 1024,
   parameter int BIAS_DEPTH = 128
) (
   input  logic            clk,
   input  logic            reset,
   param_streamer_if.slave ld,
   input  logic            start,
   input  logic            weight_en,
   input  logic            bias_en,
   output logic [DW-1:0]   wt_in,
   output logic [DW-1:0]   bias_in,
   output logic            params_ready,
   output logic            stream_done,
   output logic            underrun
`ifdef PARAM_STREAMER_CKSUM_EN
   ,
   output logic [DW-1:0]   cksum
`endif
);
   localparam int WCW = $clog2(WT_DEPTH + 1);
   localparam int BCW = $clog2(BIAS_DEPTH + 1);
   localparam int WAW = addr_w(WT_DEPTH);
   localparam int BAW = addr_w(BIAS_DEPTH);

   state_e         state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d, wptr_q, wptr_d;
   logic [BCW-1:0] bcnt_q, bcnt_d, bptr_q, bptr_d;
   logic           underrun_q, underrun_d;
   logic [DW-1:0]  w_rdata, b_rdata;
   logic           ld_ready_c, accept, w_we, b_we, w_avail, b_avail, show;
`ifdef PARAM_STREAMER_CKSUM_EN
   logic [DW-1:0]  cksum_q, cksum_d;
`endif

   param_store #(.DW(DW), .DEPTH(WT_DEPTH), .AW(WAW)) u_wt_store (
      .clk(clk), .we(w_we), .waddr(wcnt_q[WAW-1:0]), .wdata(ld.ld_data),
      .raddr(wptr_q[WAW-1:0]), .rdata(w_rdata)
   );

   param_store #(.DW(DW), .DEPTH(BIAS_DEPTH), .AW(BAW)) u_bias_store (
      .clk(clk), .we(b_we), .waddr(bcnt_q[BAW-1:0]), .wdata(ld.ld_data),
      .raddr(bptr_q[BAW-1:0]), .rdata(b_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         bcnt_q     <= '0;
         wptr_q     <= '0;
         bptr_q     <= '0;
         underrun_q <= 1'b0;
`ifdef PARAM_STREAMER_CKSUM_EN
         cksum_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         bcnt_q     <= bcnt_d;
         wptr_q     <= wptr_d;
         bptr_q     <= bptr_d;
         underrun_q <= underrun_d;
`ifdef PARAM_STREAMER_CKSUM_EN
         cksum_q    <= cksum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      bcnt_d     = bcnt_q;
      wptr_d     = wptr_q;
      bptr_d     = bptr_q;
      underrun_d = underrun_q;
`ifdef PARAM_STREAMER_CKSUM_EN
      cksum_d    = cksum_q;
`endif
      ld_ready_c = 1'b0;
      if (state_q == S_IDLE || state_q == S_LOAD)
         ld_ready_c = ld.ld_sel ? (bcnt_q != BCW'(BIAS_DEPTH)) : (wcnt_q != WCW'(WT_DEPTH));
      accept  = ld.ld_valid && ld_ready_c;
      w_we    = accept && !ld.ld_sel;
      b_we    = accept && ld.ld_sel;
      w_avail = (wptr_q != wcnt_q);
      b_avail = (bptr_q != bcnt_q);
      show    = (state_q == S_READY) || (state_q == S_STREAM);
      wt_in   = (show && w_avail) ? w_rdata : '0;
      bias_in = (show && b_avail) ? b_rdata : '0;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               wcnt_d  = wcnt_q + WCW'(w_we);
               bcnt_d  = bcnt_q + BCW'(b_we);
               state_d = ld.ld_last ? S_READY : S_LOAD;
            end
         end
         S_STREAM: begin
            if (start) begin
               wptr_d  = '0;
               bptr_d  = '0;
`ifdef PARAM_STREAMER_CKSUM_EN
               cksum_d = '0;
`endif
            end else begin
               // A consume with nothing left flags underrun but leaves the pointer put.
               if (weight_en) begin
                  if (w_avail) wptr_d = wptr_q + WCW'(1);
                  else         underrun_d = 1'b1;
               end
               if (bias_en) begin
                  if (b_avail) bptr_d = bptr_q + BCW'(1);
                  else         underrun_d = 1'b1;
               end
`ifdef PARAM_STREAMER_CKSUM_EN
               cksum_d = cksum_q + ((weight_en && w_avail) ? wt_in : '0)
                                 + ((bias_en && b_avail) ? bias_in : '0);
`endif
               if (wptr_d == wcnt_q && bptr_d == bcnt_q) state_d = S_DONE;
            end
         end
         S_READY, S_DONE: begin
            if (start) begin
               wptr_d  = '0;
               bptr_d  = '0;
`ifdef PARAM_STREAMER_CKSUM_EN
               cksum_d = '0;
`endif
               state_d = S_STREAM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ld.ld_ready   = ld_ready_c;
   assign params_ready  = (state_q == S_READY) || (state_q == S_STREAM) || (state_q == S_DONE);
   assign stream_done   = (state_q == S_DONE);
   assign underrun      = underrun_q;
`ifdef PARAM_STREAMER_CKSUM_EN
   assign cksum         = cksum_q;
`endif
endmodule

// File: tb/tb_param_streamer.sv
// tb/tb_param_streamer.sv - scoreboard bench for param_streamer.
module tb_param_streamer;
   localparam int DW = 16;
   localparam int WD = 8;
   localparam int BD = 4;

   typedef struct packed {
      logic          lr;
      logic          pr;
      logic          sd;
      logic          ur;
      logic [DW-1:0] wt;
      logic [DW-1:0] bi;
      logic [DW-1:0] ck;
   } status_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          weight_en = 1'b0;
   logic          bias_en = 1'b0;
   logic [DW-1:0] wt_in, bias_in;
   logic          params_ready, stream_done, underrun;
   logic [DW-1:0] cksum_v;
`ifdef PARAM_STREAMER_CKSUM_EN
   logic [DW-1:0] cksum;
   assign cksum_v = cksum;
`else
   assign cksum_v = '0;
`endif

   status_t       exp_st_q[$];
   logic [DW-1:0] exp_wt_q[$];
   logic [DW-1:0] exp_bi_q[$];
   logic          probe = 1'b0;
   int            checks = 0;
   int            errors = 0;
   status_t       act, exs;
   logic [DW-1:0] exw;

   param_streamer_if #(.DW(DW)) ld ();

   param_streamer #(.DW(DW), .WT_DEPTH(WD), .BIAS_DEPTH(BD)) dut (
      .clk(clk), .reset(reset), .ld(ld), .start(start),
      .weight_en(weight_en), .bias_en(bias_en),
      .wt_in(wt_in), .bias_in(bias_in), .params_ready(params_ready),
      .stream_done(stream_done), .underrun(underrun)
`ifdef PARAM_STREAMER_CKSUM_EN
      , .cksum(cksum)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      if (weight_en) begin
         checks++;
         if (exp_wt_q.size() == 0) begin
            errors++;
            $display("FAIL wt_in: consume with empty scoreboard, actual %h", wt_in);
         end else begin
            exw = exp_wt_q.pop_front();
            if (wt_in !== exw) begin
               errors++;
               $display("FAIL wt_in: actual %h required %h", wt_in, exw);
            end
         end
      end
      if (bias_en) begin
         checks++;
         if (exp_bi_q.size() == 0) begin
            errors++;
            $display("FAIL bias_in: consume with empty scoreboard, actual %h", bias_in);
         end else begin
            exw = exp_bi_q.pop_front();
            if (bias_in !== exw) begin
               errors++;
               $display("FAIL bias_in: actual %h required %h", bias_in, exw);
            end
         end
      end
      if (probe) begin
         checks++;
         act = '{lr: ld.ld_ready, pr: params_ready, sd: stream_done, ur: underrun,
                 wt: wt_in, bi: bias_in, ck: cksum_v};
         if (exp_st_q.size() == 0) begin
            errors++;
            $display("FAIL status: probe with empty scoreboard");
         end else begin
            exs = exp_st_q.pop_front();
            if (act !== exs) begin
               errors++;
               $display("FAIL status: actual lr=%b pr=%b sd=%b ur=%b wt=%h bi=%h ck=%h required lr=%b pr=%b sd=%b ur=%b wt=%h bi=%h ck=%h",
                        act.lr, act.pr, act.sd, act.ur, act.wt, act.bi, act.ck,
                        exs.lr, exs.pr, exs.sd, exs.ur, exs.wt, exs.bi, exs.ck);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      weight_en   = 1'b0;
      bias_en     = 1'b0;
      start       = 1'b0;
      ld.ld_valid = 1'b0;
      ld.ld_last  = 1'b0;
      probe       = 1'b0;
   endtask

   task automatic expect_st(input logic lr, input logic pr, input logic sd, input logic ur,
                            input logic [DW-1:0] wt, input logic [DW-1:0] bi,
                            input logic [DW-1:0] ck);
      status_t s;
      s.lr = lr; s.pr = pr; s.sd = sd; s.ur = ur; s.wt = wt; s.bi = bi;
`ifdef PARAM_STREAMER_CKSUM_EN
      s.ck = ck;
`else
      s.ck = '0;
`endif
      exp_st_q.push_back(s);
      probe = 1'b1;
   endtask

   task automatic w_en(input logic [DW-1:0] e);
      weight_en = 1'b1;
      exp_wt_q.push_back(e);
   endtask

   task automatic b_en(input logic [DW-1:0] e);
      bias_en = 1'b1;
      exp_bi_q.push_back(e);
   endtask

   task automatic load(input logic sel, input logic [DW-1:0] d, input logic last);
      ld.ld_valid = 1'b1;
      ld.ld_sel   = sel;
      ld.ld_data  = d;
      ld.ld_last  = last;
   endtask

   initial begin
      ld.ld_valid = 1'b0;
      ld.ld_sel   = 1'b0;
      ld.ld_data  = '0;
      ld.ld_last  = 1'b0;
      step(); expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step();
      step(); reset = 1'b0;
      step(); load(0, 16'h0011, 0); expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step(); load(0, 16'h0022, 0);
      step(); load(0, 16'h0033, 0);
      step(); load(1, 16'h0100, 1); expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step(); expect_st(0, 1, 0, 0, 16'h0011, 16'h0100, 16'h0);
      step(); start = 1'b1;
      step(); w_en(16'h0011);
      step(); w_en(16'h0022);
      step(); w_en(16'h0033);
      step(); expect_st(0, 1, 0, 0, 16'h0, 16'h0100, 16'h0066);
      step(); w_en(16'h0000);
      step(); expect_st(0, 1, 0, 1, 16'h0, 16'h0100, 16'h0066);
      step(); b_en(16'h0100);
      step(); expect_st(0, 1, 1, 1, 16'h0, 16'h0, 16'h0166);
      step(); start = 1'b1;
      step(); expect_st(0, 1, 0, 1, 16'h0011, 16'h0100, 16'h0);
      step(); w_en(16'h0011); b_en(16'h0100);
      step(); w_en(16'h0022);
      step(); w_en(16'h0033);
      step(); expect_st(0, 1, 1, 1, 16'h0, 16'h0, 16'h0166);
      step(); start = 1'b1;
      step(); w_en(16'h0011);
      step(); start = 1'b1; w_en(16'h0022);
      step(); expect_st(0, 1, 0, 1, 16'h0011, 16'h0100, 16'h0);
      step(); w_en(16'h0011);
      step(); reset = 1'b1; expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step(); reset = 1'b0; start = 1'b1;
      step(); expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step(); w_en(16'h0000); b_en(16'h0000);
      step(); expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < WD; i++) begin
         step(); load(0, 16'h1000 + 16'(i), 0);
      end
      step(); load(0, 16'hdead, 0); expect_st(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step(); load(1, 16'h0200, 1); expect_st(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      step(); expect_st(0, 1, 0, 0, 16'h1000, 16'h0200, 16'h0);
      step(); start = 1'b1;
      for (int i = 0; i < WD; i++) begin
         step(); w_en(16'h1000 + 16'(i));
      end
      step(); expect_st(0, 1, 0, 0, 16'h0, 16'h0200, 16'h801c);
      step(); b_en(16'h0200);
      step(); expect_st(0, 1, 1, 0, 16'h0, 16'h0, 16'h821c);
      step();
      step();
      checks++;
      if (exp_st_q.size() != 0 || exp_wt_q.size() != 0 || exp_bi_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual %0d/%0d/%0d pending required 0/0/0",
                  exp_st_q.size(), exp_wt_q.size(), exp_bi_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/param_streamer.md
PARAM_STREAMER -- requirements
Module: param_streamer

Interface
REQ-001 SHALL have parameter DW, default 16, parameter word width in bits.
REQ-002 SHALL have parameter WT_DEPTH, default 1024, weight store capacity in words.
REQ-003 SHALL have parameter BIAS_DEPTH, default 128, bias store capacity in words.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ld_valid  input  1  host load word valid.
REQ-007 ld_ready  output  1  block can accept a load word.
REQ-008 ld_sel  input  1  load target: 0 selects weight store, 1 selects bias store.
REQ-009 ld_data  input  DW  load word.
REQ-010 ld_last  input  1  qualifies final load word of the load phase.
REQ-011 start  input  1  one-cycle pulse that begins or rewinds streaming.
REQ-012 weight_en  input  1  engine consumes wt_in this cycle.
REQ-013 bias_en  input  1  engine consumes bias_in this cycle.
REQ-014 wt_in  output  DW  current weight word to the engine.
REQ-015 bias_in  output  DW  current bias word to the engine.
REQ-016 params_ready  output  1  load phase complete, store valid.
REQ-017 stream_done  output  1  all loaded weights and biases consumed.
REQ-018 underrun  output  1  sticky: a consume occurred with no word remaining.

Function
REQ-019 SHALL implement states IDLE, LOAD, READY, STREAM, DONE.
REQ-020 IDLE->LOAD on first accepted load word; LOAD->READY on accepted word with ld_last=1.
REQ-021 Load transfer SHALL occur only when ld_valid and ld_ready are both 1 on a rising edge.
REQ-022 ld_ready SHALL be 1 in IDLE/LOAD unless the store selected by ld_sel is full (count = WT_DEPTH or BIAS_DEPTH), then 0.
REQ-023 Each accepted word SHALL be written at the selected store's write count, which then increments; words are emitted in load order.
REQ-024 READY->STREAM on start; start clears both read pointers.
REQ-025 In READY and STREAM, wt_in SHALL equal weight word at the weight read pointer and bias_in the bias word at the bias read pointer, combinationally valid in the same cycle as the enable (zero latency, no bubble on back-to-back enables).
REQ-026 A rising edge with weight_en=1 in STREAM SHALL advance the weight read pointer by one; bias_en likewise for the bias pointer; simultaneous enables advance both independently.
REQ-027 When a read pointer equals its loaded count, the matching output SHALL be 0; a consume then sets underrun and leaves the pointer unchanged.
REQ-028 STREAM->DONE when both read pointers equal their loaded counts; stream_done=1 in DONE.
REQ-029 start in STREAM or DONE SHALL rewind both read pointers and enter STREAM; start in IDLE/LOAD SHALL be ignored.
REQ-030 Enables outside STREAM SHALL be ignored and not set underrun.
REQ-031 ld_ready SHALL be 0 in READY, STREAM, DONE.
REQ-032 params_ready SHALL be 1 in READY, STREAM, DONE.

Reset
REQ-033 reset SHALL force IDLE, clear write counts, read pointers and underrun; outputs: ld_ready=1, wt_in=0, bias_in=0, params_ready=0, stream_done=0, underrun=0.
REQ-034 reset mid-load or mid-stream SHALL discard loaded counts; store contents need not be cleared.

Configuration
REQ-035 With PARAM_STREAMER_CKSUM_EN defined, SHALL add output cksum (DW) = modulo-2^DW sum of every word consumed since last start/reset, updated the edge after consumption.
REQ-036 Without PARAM_STREAMER_CKSUM_EN, cksum port and adder SHALL be absent.

Structure
REQ-037 State encoding typedef and DW default SHALL live in shared package nn_pkg.
REQ-038 Weight and bias stores SHALL each be an instance of one sub-module param_store (single write port, asynchronous read port).

Verification
REQ-039 Load weights 0x0011,0x0022,0x0033 and bias 0x0100 with ld_last, start, weight_en 3 back-to-back cycles -> wt_in 0x0011,0x0022,0x0033 in consecutive cycles, then 0.
REQ-040 weight_en and bias_en together on same edge -> both pointers advance; after all consumed stream_done=1.
REQ-041 Extra weight_en after last weight -> underrun=1 sticky, wt_in=0, pointer unchanged.
REQ-042 Fill weight store to WT_DEPTH -> ld_ready=0 while ld_sel=0, 1 when ld_sel=1.
REQ-043 start in DONE -> wt_in returns to 0x0011, stream_done=0, underrun retained.
REQ-044 reset asserted mid-stream -> all outputs at reset values immediately, state IDLE, with CKSUM_EN cksum=0.
